ir_queue: RTL
=============

Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH prefetched instructions from RAM in a circular FIFO, using a valid/ready handshake.
- Advances a decode register from the FIFO head on IR_Load.
- Presents the head instruction as Opcode / Source_Reg1 / Source_Reg2 / Dest_Reg fields to the control unit and register file. Supports pipeline flush on branch.

Parameters:
- OPCODE_WIDTH, 3, opcode field width.
- ADDR_WIDTH, 6, width of each register-address field.
- INST_WIDTH, OPCODE_WIDTH+3*ADDR_WIDTH (21), instruction width. Derived; not overridable independently.
- DEPTH, 4, FIFO entries. Power of two, ≥2.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous discard of all queued and current instructions.
- Ram_Inst_Out  in  INST_WIDTH  instruction word from RAM.
- Ram_Valid  in  1  Ram_Inst_Out is valid this cycle.
- Ram_Ready  out  1  FIFO accepts a word this cycle.
- IR_Load  in  1  advance decode register from FIFO head.
- IR_Valid  out  1  decode register holds a live instruction.
- Opcode  out  OPCODE_WIDTH  IR[INST_WIDTH-1 -: OPCODE_WIDTH].
- Source_Reg1  out  ADDR_WIDTH  next ADDR_WIDTH bits below the opcode.
- Source_Reg2  out  ADDR_WIDTH  next ADDR_WIDTH bits.
- Dest_Reg  out  ADDR_WIDTH  IR[ADDR_WIDTH-1:0].
- Count  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH; excludes the decode register.
- Full  out  1  Count==DEPTH.
- Empty  out  1  Count==0.

Behaviour:
- Reset (Rst_n=0, async, no clock needed):
  - wr_ptr, rd_ptr, Count, IR, IR_Valid all 0.
  - Empty=1, Full=0, Ram_Ready=1.
  - FIFO storage contents need not be cleared.
- Push: Ram_Valid & Ram_Ready at an edge writes Ram_Inst_Out to entry wr_ptr; wr_ptr increments modulo DEPTH.
- Ram_Ready = !Full, combinational from registered Count. No push while full, even if a pop occurs in the same cycle (no pass-through).
- Pop: IR_Load & !Empty at an edge copies entry rd_ptr into IR, sets IR_Valid=1, and increments rd_ptr modulo DEPTH.
- IR_Load & Empty: IR_Valid←0 and IR holds its old value (the field outputs are stale but defined). There is no bypass from Ram_Inst_Out to IR.
- IR_Load=0: IR and IR_Valid hold.
- Latency: a word pushed at edge N is poppable at edge N+1 at the earliest. Fields change the cycle after the popping edge.
- Simultaneous push and pop (not full, not empty): Count unchanged, both pointers advance.
- Count update: +1 on push only, −1 on pop only, otherwise unchanged.
- Pointer wrap: pointers carry $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/Empty derive from Count, not pointer compare.
- Flush=1 at an edge:
  - wr_ptr, rd_ptr, Count ← 0; IR_Valid ← 0.
  - IR field values hold.
  - Flush has priority: any push or pop in the same cycle is dropped.
- Field outputs are continuous slices of the IR register; there is no combinational path from inputs.
- Reset mid-operation: all state returns to reset values immediately. Words queued before the reset are never issued.

Optional Feature:
- Macro: IR_PARITY_EN.
- Defined:
  - Adds input Ram_Parity (1, even parity over Ram_Inst_Out), stored per entry.
  - Adds output Parity_Err (1, registered, reset 0).
  - On each pop, if ^entry != stored parity, Parity_Err←1.
  - Parity_Err is sticky until Flush or Rst_n; Flush clears it with priority over a same-edge set.
  - IR_Valid behaviour is unchanged.
- Undefined: Ram_Parity and Parity_Err ports are absent, no parity storage is built, and behaviour is otherwise identical.

Test Plan:
- Reset check: Rst_n low mid-cycle -> immediately Count=0, Empty=1, Ram_Ready=1, IR_Valid=0, Opcode=0.
- Fill: push 4 words with Ram_Valid=1 and IR_Load=0 -> Count=4, Full=1, Ram_Ready=0; a 5th word held 3 cycles is not accepted and Count stays 4.
- Decode order: push 21'b101_000011_000101_111111, then 21'b010_100000_000001_000010; pulse IR_Load twice -> first Opcode=101, S1=3, S2=5, D=63, IR_Valid=1; then Opcode=010, S1=32, S2=1, D=2.
- Concurrent and wrap: at Count=2, Ram_Valid=1 and IR_Load=1 for 6 cycles -> Count stays 2, pointers wrap, issued order equals pushed order. IR_Load on empty -> IR_Valid=0, fields unchanged.
- Flush: Count=3 with Flush, Ram_Valid and IR_Load in the same cycle -> next cycle Count=0, IR_Valid=0, pushed word discarded.
- Parity (IR_PARITY_EN): push 21'h000001 with Ram_Parity=0, then pop -> Parity_Err=1 and held; next Flush -> Parity_Err=0.

Source files
------------

// File: rtl/ir_queue.sv
// ir_queue: prefetch FIFO feeding a decode (instruction) register.
// Words from RAM are buffered in a DEPTH-entry circular queue via a
// valid/ready handshake, then moved into the decode register on IR_Load.
// Optional feature macro: IR_PARITY_EN (per-entry even parity, sticky error).
module ir_queue #(
    parameter int OPCODE_WIDTH = 3,
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 4,
    localparam int INST_WIDTH  = OPCODE_WIDTH + 3 * ADDR_WIDTH,
    localparam int CNT_W       = $clog2(DEPTH + 1),
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Flush,
    input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
    input  logic                    Ram_Valid,
    output logic                    Ram_Ready,
    input  logic                    IR_Load,
    output logic                    IR_Valid,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic [ADDR_WIDTH-1:0]   Source_Reg1,
    output logic [ADDR_WIDTH-1:0]   Source_Reg2,
    output logic [ADDR_WIDTH-1:0]   Dest_Reg,
    output logic [CNT_W-1:0]        Count,
    output logic                    Full,
    output logic                    Empty
`ifdef IR_PARITY_EN
    ,
    input  logic                    Ram_Parity,
    output logic                    Parity_Err
`endif
);

    // Handshake: a word transfers from RAM at a rising edge when
    // Ram_Valid && Ram_Ready. Ram_Ready depends only on registered Count,
    // so a pop in the same cycle never frees a slot for a push (no
    // pass-through). Flush drops any transfer in its cycle.

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [INST_WIDTH-1:0] ir;
    logic                  push;
    logic                  pop;

    assign Full      = (Count == CNT_W'(DEPTH));
    assign Empty     = (Count == '0);
    assign Ram_Ready = !Full;

    assign push = Ram_Valid && !Full && !Flush;
    assign pop  = IR_Load && !Empty && !Flush;

    // Decode fields are plain slices of the registered IR.
    assign Opcode      = ir[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign Source_Reg1 = ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign Source_Reg2 = ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign Dest_Reg    = ir[ADDR_WIDTH-1:0];

    // Queue storage: written on push only; contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= Ram_Inst_Out;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Decode register: loads the head on pop; a load from an empty queue
    // only invalidates, leaving the stale fields in place. Flush keeps fields.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ir       <= '0;
            IR_Valid <= 1'b0;
        end else if (Flush) begin
            IR_Valid <= 1'b0;
        end else if (IR_Load) begin
            IR_Valid <= !Empty;
            if (!Empty) begin
                ir <= mem[rd_ptr];
            end
        end
    end

`ifdef IR_PARITY_EN
    logic par_mem [DEPTH];

    // Parity storage travels alongside each queued word.
    always_ff @(posedge Clk) begin
        if (push) begin
            par_mem[wr_ptr] <= Ram_Parity;
        end
    end

    // Sticky parity error, checked on each pop; Flush clears with priority.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Parity_Err <= 1'b0;
        end else if (Flush) begin
            Parity_Err <= 1'b0;
        end else if (pop && ((^mem[rd_ptr]) != par_mem[rd_ptr])) begin
            Parity_Err <= 1'b1;
        end
    end
`endif

endmodule
